// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared types and constants for the forwarding/hazard unit
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF      = 2'b00,
        FWD_EX      = 2'b01,
        FWD_MEM_ALU = 2'b10,
        FWD_MEM_LD  = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - decode-stage operand/stall bundle between pipeline and hazard unit
interface fwd_hazard_unit_if #(
  parameter int NREAD = 2,
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic [NREAD*AW-1:0] id_rs_addr;
  logic [NREAD-1:0]    id_rs_used;
  logic [AW-1:0]       ex_rd;
  logic                ex_wen;
  logic                ex_is_load;
  logic [AW-1:0]       mem_rd;
  logic                mem_wen;
  logic                mem_wb_sel;
  logic                mem_is_load;
  logic                mem_rsp_valid;
  logic                flush_ex;
  logic [NREAD*2-1:0]  fwd_sel;
  logic                stall_pc;
  logic                stall_ifid;
  logic                bubble_idex;
  logic                freeze_back;
  logic                timeout_err;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output id_rs_addr, id_rs_used, ex_rd, ex_wen, ex_is_load, mem_rd, mem_wen,
           mem_wb_sel, mem_is_load, mem_rsp_valid, flush_ex,
    input  fwd_sel, stall_pc, stall_ifid, bubble_idex, freeze_back, timeout_err, stall_cnt
  );

  modport slave (
    input  id_rs_addr, id_rs_used, ex_rd, ex_wen, ex_is_load, mem_rd, mem_wen,
           mem_wb_sel, mem_is_load, mem_rsp_valid, flush_ex,
    output fwd_sel, stall_pc, stall_ifid, bubble_idex, freeze_back, timeout_err, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit_fwd_port_sel.sv
// rtl/fwd_hazard_unit_fwd_port_sel.sv - forwarding select for one decode source port
module fwd_port_sel
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] addr_i,
  input  logic [AW-1:0] ex_rd_i,
  input  logic          ex_wen_i,
  input  logic [AW-1:0] mem_rd_i,
  input  logic          mem_wen_i,
  input  logic          mem_wb_sel_i,
  output fwd_sel_e      fwd_sel_o,
  output logic          hit_ex_o
);
  logic hit_mem;

  assign hit_ex_o = ex_wen_i && (ex_rd_i != AW'(REG_ZERO)) && (addr_i == ex_rd_i);
  assign hit_mem  = mem_wen_i && (mem_rd_i != AW'(REG_ZERO)) && (addr_i == mem_rd_i);

  // The younger producer in EX holds the newest value, so it wins over MEM.
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (hit_ex_o) begin
      fwd_sel_o = FWD_EX;
    end else if (hit_mem) begin
      fwd_sel_o = mem_wb_sel_i ? FWD_MEM_ALU : FWD_MEM_LD;
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - ID-stage forwarding selects, load-use interlock and MEM wait freeze
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NREAD   = 2,
  parameter int AW      = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fwd_hazard_unit_if.slave  bus
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [NREAD-1:0]   hit_ex;
  logic [NREAD*2-1:0] sel_raw;

  for (genvar g = 0; g < NREAD; g++) begin : g_port
    fwd_sel_e sel;

    fwd_port_sel #(.AW(AW)) u_sel (
      .addr_i       (bus.id_rs_addr[g*AW +: AW]),
      .ex_rd_i      (bus.ex_rd),
      .ex_wen_i     (bus.ex_wen),
      .mem_rd_i     (bus.mem_rd),
      .mem_wen_i    (bus.mem_wen),
      .mem_wb_sel_i (bus.mem_wb_sel),
      .fwd_sel_o    (sel),
      .hit_ex_o     (hit_ex[g])
    );

    assign sel_raw[g*2 +: 2] = sel;
  end

  logic lu;
  logic mem_stall;
  logic stall_any;

  assign lu        = bus.ex_is_load && (|(bus.id_rs_used & hit_ex)) && !bus.flush_ex;
  assign mem_stall = bus.mem_is_load && !bus.mem_rsp_valid;
  assign stall_any = mem_stall || lu;

  hz_state_e        state_q;
  logic [WAIT_W-1:0] wait_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  // wait_q holds the number of consecutive stalled cycles seen so far, capped at TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (stall_any && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q <= MEM_WAIT;
            wait_q  <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            if (wait_q == WAIT_W'(TIMEOUT)) begin
              err_q <= 1'b1;
            end else begin
              wait_q <= wait_q + WAIT_W'(1);
            end
          end else begin
            state_q <= RUN;
            wait_q  <= '0;
          end
        end
        default: begin
          state_q <= RUN;
          wait_q  <= '0;
        end
      endcase
    end
  end

  // Everything is masked while reset is asserted, even before the first edge lands.
  assign bus.fwd_sel     = rst_n ? sel_raw : '0;
  assign bus.stall_pc    = rst_n && stall_any;
  assign bus.stall_ifid  = rst_n && stall_any;
  assign bus.bubble_idex = rst_n && lu && !mem_stall;
  assign bus.freeze_back = rst_n && mem_stall;
  assign bus.timeout_err = rst_n && err_q;
  assign bus.stall_cnt   = rst_n ? cnt_q : '0;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed and randomized checks of fwd_hazard_unit against a reference model
module tb_fwd_hazard_unit;
  localparam int NREAD   = 2;
  localparam int AW      = 5;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NREAD(NREAD), .AW(AW), .CNT_W(CNT_W)) bus ();

  fwd_hazard_unit #(.NREAD(NREAD), .AW(AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int run_m    = 0;
  bit err_m    = 1'b0;
  int cnt_m    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_sel(input int port);
    logic [AW-1:0] a;
    a = bus.id_rs_addr[port*AW +: AW];
    if (a != 0 && bus.ex_wen && bus.ex_rd == a) return 2'b01;
    if (a != 0 && bus.mem_wen && bus.mem_rd == a) return bus.mem_wb_sel ? 2'b10 : 2'b11;
    return 2'b00;
  endfunction

  function automatic bit ref_lu();
    bit dep = 1'b0;
    for (int i = 0; i < NREAD; i++)
      if (bus.id_rs_used[i] && ref_sel(i) == 2'b01) dep = 1'b1;
    return bus.ex_is_load && dep && !bus.flush_ex;
  endfunction

  function automatic bit ref_ms();
    return bus.mem_is_load && !bus.mem_rsp_valid;
  endfunction

  task automatic compare_all(input string tag);
    logic [NREAD*2-1:0] sel;
    bit lu, ms, on;
    on = (rst_n === 1'b1);
    lu = ref_lu();
    ms = ref_ms();
    for (int i = 0; i < NREAD; i++) sel[i*2 +: 2] = on ? ref_sel(i) : 2'b00;
    check({tag, ".fwd_sel"},     32'(bus.fwd_sel),     32'(sel));
    check({tag, ".stall_pc"},    32'(bus.stall_pc),    32'(on && (lu || ms)));
    check({tag, ".stall_ifid"},  32'(bus.stall_ifid),  32'(on && (lu || ms)));
    check({tag, ".bubble_idex"}, 32'(bus.bubble_idex), 32'(on && lu && !ms));
    check({tag, ".freeze_back"}, 32'(bus.freeze_back), 32'(on && ms));
    check({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(on && err_m));
    check({tag, ".stall_cnt"},   32'(bus.stall_cnt),   on ? 32'(cnt_m) : 32'd0);
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    compare_all(tag);
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      run_m = 0;
      err_m = 1'b0;
      cnt_m = 0;
    end else begin
      if ((ref_lu() || ref_ms()) && cnt_m < CNT_MAX) cnt_m++;
      if (ref_ms()) begin
        if (run_m < 1000) run_m++;
        if (run_m >= TIMEOUT + 1) err_m = 1'b1;
      end else begin
        run_m = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    bus.id_rs_addr    = '0;
    bus.id_rs_used    = '0;
    bus.ex_rd         = '0;
    bus.ex_wen        = 1'b0;
    bus.ex_is_load    = 1'b0;
    bus.mem_rd        = '0;
    bus.mem_wen       = 1'b0;
    bus.mem_wb_sel    = 1'b1;
    bus.mem_is_load   = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.flush_ex      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle("rst");
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NREAD; i++) bus.id_rs_addr[i*AW +: AW] = AW'($urandom_range(0, 6));
    bus.id_rs_used    = NREAD'($urandom);
    bus.ex_rd         = AW'($urandom_range(0, 6));
    bus.ex_wen        = 1'($urandom);
    bus.ex_is_load    = 1'($urandom);
    bus.mem_rd        = AW'($urandom_range(0, 6));
    bus.mem_wen       = 1'($urandom);
    bus.mem_wb_sel    = 1'($urandom);
    bus.mem_is_load   = 1'($urandom);
    bus.mem_rsp_valid = ($urandom_range(0, 3) != 0);
    bus.flush_ex      = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    bus.id_rs_addr[4:0] = 5'd5;
    bus.ex_rd  = 5'd5;
    bus.ex_wen = 1'b1;
    bus.ex_is_load = 1'b1;
    bus.id_rs_used = 2'b01;
    #1;
    check("reset_fwd_masked", 32'(bus.fwd_sel), 32'd0);
    check("reset_stall_masked", 32'(bus.stall_pc), 32'd0);
    cycle("reset");
    rst_n = 1'b1;

    idle();
    bus.id_rs_addr[4:0] = 5'd5;
    bus.ex_rd = 5'd5;  bus.ex_wen = 1'b1;
    bus.mem_rd = 5'd5; bus.mem_wen = 1'b1;
    #1;
    check("ex_priority", 32'(bus.fwd_sel[1:0]), 32'h1);
    cycle("ex_priority");
    bus.ex_wen = 1'b0; bus.mem_wb_sel = 1'b0;
    #1;
    check("mem_load_sel", 32'(bus.fwd_sel[1:0]), 32'h3);
    cycle("mem_load_sel");

    idle();
    bus.ex_wen = 1'b1; bus.mem_wen = 1'b1; bus.ex_is_load = 1'b1; bus.id_rs_used = 2'b11;
    #1;
    check("zero_addr_fwd", 32'(bus.fwd_sel), 32'h0);
    check("zero_addr_stall", 32'(bus.stall_pc), 32'h0);
    cycle("zero_addr");

    idle();
    bus.ex_is_load = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 5'd7;
    bus.id_rs_addr[9:5] = 5'd7; bus.id_rs_used = 2'b10;
    #1;
    check("lu_bubble", 32'(bus.bubble_idex), 32'h1);
    cycle("lu");
    idle();
    bus.mem_rd = 5'd7; bus.mem_wen = 1'b1; bus.mem_wb_sel = 1'b0;
    bus.mem_is_load = 1'b1; bus.mem_rsp_valid = 1'b1;
    bus.id_rs_addr[9:5] = 5'd7; bus.id_rs_used = 2'b10;
    #1;
    check("lu_after_sel", 32'(bus.fwd_sel[3:2]), 32'h3);
    check("lu_after_stall", 32'(bus.stall_pc), 32'h0);
    cycle("lu_after");
    idle();
    bus.ex_is_load = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 5'd7;
    bus.id_rs_addr[9:5] = 5'd7; bus.id_rs_used = 2'b01;
    cycle("lu_unused");
    bus.id_rs_used = 2'b10; bus.flush_ex = 1'b1;
    cycle("lu_flushed");

    idle();
    do_reset();
    bus.mem_is_load = 1'b1;
    for (int k = 0; k < 3; k++) cycle("mem_wait");
    bus.mem_rsp_valid = 1'b1;
    #1;
    check("mem_wait_cnt", 32'(bus.stall_cnt), 32'd3);
    check("mem_wait_release", 32'(bus.freeze_back), 32'd0);
    cycle("mem_release");
    bus.mem_is_load = 1'b0;
    cycle("mem_done");

    idle();
    bus.ex_is_load = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 5'd3;
    bus.id_rs_addr[4:0] = 5'd3; bus.id_rs_used = 2'b01;
    bus.mem_is_load = 1'b1; bus.flush_ex = 1'b1;
    #1;
    check("concurrent_freeze", 32'(bus.freeze_back), 32'd1);
    check("concurrent_bubble", 32'(bus.bubble_idex), 32'd0);
    cycle("concurrent");

    idle();
    do_reset();
    bus.mem_is_load = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle("timeout");
      check("timeout_edge", 32'(bus.timeout_err), 32'(k >= TIMEOUT + 1));
    end
    bus.mem_rsp_valid = 1'b1;
    cycle("timeout_sticky");
    check("timeout_sticky_hold", 32'(bus.timeout_err), 32'd1);
    idle();
    do_reset();
    check("timeout_cleared", 32'(bus.timeout_err), 32'd0);
    check("cnt_cleared", 32'(bus.stall_cnt), 32'd0);

    for (int n = 0; n < 500; n++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 60) != 0);
      cycle("random");
    end
    rst_n = 1'b1;
    idle();
    cycle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised successor to the two-port forwarding selector. Sits in the ID stage of the 5-stage pipeline and generates per-source-port forwarding selects for NREAD read ports. It also detects load-use hazards and inserts the interlock bubble. A small FSM freezes the pipeline while a load in MEM waits on a multi-cycle data memory, with a wait-timeout error flag and a saturating stall-cycle counter.

## Interface
- NREAD, 2, number of decode-stage source register ports
- AW, 5, register address width; address 0 is hard-wired zero
- TIMEOUT, 64, max MEM_WAIT cycles before timeout_err sets (≥2)
- CNT_W, 16, stall-cycle counter width
- clk  in  1  core clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- id_rs_addr  in  NREAD*AW  source register addresses; port i at [i*AW +: AW]
- id_rs_used  in  NREAD  port i actually read by the ID instruction
- ex_rd  in  AW  destination of instruction in EX (2r)
- ex_wen  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- mem_rd  in  AW  destination of instruction in MEM (3r)
- mem_wen  in  1  MEM instruction writes rd
- mem_wb_sel  in  1  1 = MEM writes back ALU result, 0 = load data
- mem_is_load  in  1  MEM instruction is a load awaiting data
- mem_rsp_valid  in  1  load data valid this cycle
- flush_ex  in  1  branch resolved taken in EX; ID instruction is killed
- fwd_sel  out  NREAD*2  per port: 00 regfile, 01 EX result, 10 MEM ALU result, 11 MEM load data
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID register
- bubble_idex  out  1  load NOP into ID/EX
- freeze_back  out  1  hold ID/EX, EX/MEM, MEM/WB
- timeout_err  out  1  sticky: MEM_WAIT exceeded TIMEOUT
- stall_cnt  out  CNT_W  saturating count of cycles with stall_pc high

## Operation
- Forwarding, per port i:
  - hit_ex = ex_wen & ex_rd≠0 & addr==ex_rd.
  - hit_mem = mem_wen & mem_rd≠0 & addr==mem_rd.
  - hit_ex → 01, else hit_mem → (mem_wb_sel ? 10 : 11), else 00.
  - EX beats MEM. Address 0 never forwards at either stage.
- Load-use: lu = ex_is_load & any_i(id_rs_used[i] & hit_ex[i]) & ~flush_ex.
- mem_stall = mem_is_load & ~mem_rsp_valid.
- Stall precedence: mem_stall > lu.
  - mem_stall: stall_pc = stall_ifid = freeze_back = 1, bubble_idex = 0, flush_ex ignored. Upstream holds flush_ex until the freeze ends.
  - lu alone: stall_pc = stall_ifid = bubble_idex = 1, freeze_back = 0.
  - Otherwise all stall outputs 0.
- FSM states RUN, MEM_WAIT:
  - RUN→MEM_WAIT when mem_stall; wait_cnt←1.
  - MEM_WAIT: wait_cnt increments (saturating at TIMEOUT) while mem_stall.
  - When wait_cnt==TIMEOUT and still stalled, timeout_err←1; it stays set until reset.
  - MEM_WAIT→RUN on first cycle mem_stall is low; wait_cnt←0.
  - Freeze outputs are combinational from mem_stall in both states. The FSM only tracks wait length.
- stall_cnt increments each cycle stall_pc = 1 and saturates at all-ones.

## Timing
- fwd_sel and all stall/bubble/freeze outputs are combinational, valid in the same cycle as inputs. No added latency.
- While rst_n = 0 (sampled), every output is forced to 0: fwd_sel = 0, stalls 0, timeout_err 0, stall_cnt 0.
- On the next edge after reset: state = RUN, wait_cnt = 0.
- A load-use stall lasts exactly 1 cycle. The following cycle the load sits in MEM, and the dependent port gets 11, or mem_stall freezes first.
- Reset asserted mid-MEM_WAIT returns the FSM to RUN at the next edge. timeout_err clears.
- mem_rsp_valid in the same cycle mem_is_load first rises: no stall, FSM stays RUN.
- timeout_err rises on the edge where the stall reaches TIMEOUT+1 consecutive cycles.

## Structure
- hazard_pkg: typedef enum logic[1:0] fwd_sel_e {FWD_RF, FWD_EX, FWD_MEM_ALU, FWD_MEM_LD}; typedef enum logic hz_state_e {RUN, MEM_WAIT}; constant REG_ZERO.
- Sub-module fwd_port_sel: one per read port (generate loop, NREAD instances). Produces that port's fwd_sel and hit_ex.
- The top holds the stall logic, the FSM and the counters.

## Test plan
- Port0 addr=5, ex_rd=5, ex_wen=1, mem_rd=5, mem_wen=1 → fwd_sel[1:0]=01 (EX priority). With ex_wen=0 and mem_wb_sel=0 → 11.
- addr=0 on both ports, ex_rd=0, mem_rd=0, wen=1 → fwd_sel=0000 and no stall.
- ex_is_load=1, ex_rd=7, port1 addr=7 used → stall_pc/stall_ifid/bubble_idex high for 1 cycle. Same stimulus with id_rs_used[1]=0 or flush_ex=1 → no stall.
- mem_is_load=1 with mem_rsp_valid low 3 cycles, then high → freeze_back high exactly 3 cycles, stall_cnt advances by 3, FSM back to RUN.
- Concurrent lu and mem_stall → freeze_back=1, bubble_idex=0.
- TIMEOUT=4, mem_rsp_valid held low 6 cycles → timeout_err rises after the 5th stalled cycle and stays high. Then rst_n=0 for 1 cycle → timeout_err=0, stall_cnt=0.
